// File: rtl/byteswap_kernel_ctrl.sv
`default_nettype none
// ============================================================================
//  Module      : byteswap_kernel_ctrl
//  Description : ap_ctrl_hs sequencer in front of the vswap datapath stage.
//                Latches the host scalar arguments when ap_start is seen in
//                IDLE. Issues a one-cycle vswap_start pulse and waits for
//                vswap_done. It then returns ap_done/ap_ready for one cycle
//                and goes back to IDLE. Zero-length transfers skip the
//                datapath entirely. A saturating counter records the number
//                of cycles spent in START+RUN.
//  Revision    : 1.0 - initial release
// ----------------------------------------------------------------------------
//  Ports
//    ap_clk                  in   kernel clock
//    ap_rst_n                in   synchronous active-low reset
//    ap_start                in   level start from the control slave
//    ap_idle                 out  high while in IDLE
//    ap_done                 out  one-cycle completion pulse
//    ap_ready                out  one-cycle pulse, coincident with ap_done
//    arg_addr_offset         in   host buffer address argument
//    arg_xfer_size           in   host transfer size in bytes
//    arg_constant            in   host constant argument
//    ctrl_addr_offset        out  latched address to the datapath
//    ctrl_xfer_size_in_bytes out  latched size to the datapath
//    ctrl_constant           out  latched constant to the datapath
//    vswap_start             out  one-cycle start pulse to the datapath
//    vswap_done              in   completion pulse from the datapath
//    busy_cycles             out  START+RUN cycles of the last/current run
// ============================================================================
module byteswap_kernel_ctrl #(
    parameter int C_M_AXI_ADDR_WIDTH = 64,
    parameter int C_XFER_SIZE_WIDTH  = 32,
    parameter int C_WORD_BIT_WIDTH   = 32,
    parameter int C_CNT_WIDTH        = 32
) (
    input  logic                          ap_clk,
    input  logic                          ap_rst_n,
    input  logic                          ap_start,
    output logic                          ap_idle,
    output logic                          ap_done,
    output logic                          ap_ready,
    input  logic [C_M_AXI_ADDR_WIDTH-1:0] arg_addr_offset,
    input  logic [C_XFER_SIZE_WIDTH-1:0]  arg_xfer_size,
    input  logic [C_WORD_BIT_WIDTH-1:0]   arg_constant,
    output logic [C_M_AXI_ADDR_WIDTH-1:0] ctrl_addr_offset,
    output logic [C_XFER_SIZE_WIDTH-1:0]  ctrl_xfer_size_in_bytes,
    output logic [C_WORD_BIT_WIDTH-1:0]   ctrl_constant,
    output logic                          vswap_start,
    input  logic                          vswap_done,
    output logic [C_CNT_WIDTH-1:0]        busy_cycles
);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_START = 2'd1,
        S_RUN   = 2'd2,
        S_DONE  = 2'd3
    } state_t;

    localparam logic [C_CNT_WIDTH-1:0] c_cnt_max = '1;

    state_t                          r_state;
    logic                            r_idle;
    logic                            r_done;
    logic                            r_ready;
    logic                            r_vstart;
    logic [C_M_AXI_ADDR_WIDTH-1:0]   r_addr;
    logic [C_XFER_SIZE_WIDTH-1:0]    r_size;
    logic [C_WORD_BIT_WIDTH-1:0]     r_const;
    logic [C_CNT_WIDTH-1:0]          r_busy;

    logic                            w_busy_active;
    logic                            w_busy_sat;

    // The counter accumulates only while the kernel is actually working.
    assign w_busy_active = (r_state == S_START) || (r_state == S_RUN);
    assign w_busy_sat    = (r_busy == c_cnt_max);

    always_ff @(posedge ap_clk) begin
        if (!ap_rst_n) begin
            r_state  <= S_IDLE;
            r_idle   <= 1'b1;
            r_done   <= 1'b0;
            r_ready  <= 1'b0;
            r_vstart <= 1'b0;
            r_addr   <= '0;
            r_size   <= '0;
            r_const  <= '0;
            r_busy   <= '0;
        end else begin
            // Pulse outputs default low; each state raises them explicitly.
            r_done   <= 1'b0;
            r_ready  <= 1'b0;
            r_vstart <= 1'b0;

            if (w_busy_active && !w_busy_sat) begin
                r_busy <= r_busy + 1'b1;
            end

            case (r_state)
                S_IDLE: begin
                    if (ap_start) begin
                        r_addr   <= arg_addr_offset;
                        r_size   <= arg_xfer_size;
                        r_const  <= arg_constant;
                        r_busy   <= '0;
                        r_idle   <= 1'b0;
                        r_state  <= S_START;
                        // The pulse is registered, so it is decided from the
                        // live argument here; it then lines up exactly with
                        // the START cycle. A zero-length run never pulses.
                        r_vstart <= (arg_xfer_size != '0);
                    end
                end

                S_START: begin
                    // vswap_done is deliberately not looked at here: the
                    // datapath cannot finish in the cycle it is started.
                    if (r_size == '0) begin
                        r_state <= S_DONE;
                        r_done  <= 1'b1;
                        r_ready <= 1'b1;
                    end else begin
                        r_state <= S_RUN;
                    end
                end

                S_RUN: begin
                    if (vswap_done) begin
                        r_state <= S_DONE;
                        r_done  <= 1'b1;
                        r_ready <= 1'b1;
                    end
                end

                S_DONE: begin
                    // ap_start is not sampled here; a held start is picked up
                    // in the following IDLE cycle, so ap_idle is visible for
                    // one cycle between back-to-back runs.
                    r_state <= S_IDLE;
                    r_idle  <= 1'b1;
                end

                default: begin
                    r_state <= S_IDLE;
                    r_idle  <= 1'b1;
                end
            endcase
        end
    end

    assign ap_idle                 = r_idle;
    assign ap_done                 = r_done;
    assign ap_ready                = r_ready;
    assign vswap_start             = r_vstart;
    assign ctrl_addr_offset        = r_addr;
    assign ctrl_xfer_size_in_bytes = r_size;
    assign ctrl_constant           = r_const;
    assign busy_cycles             = r_busy;

endmodule
`default_nettype wire

// File: tb/tb_byteswap_kernel_ctrl.sv
`default_nettype none
// ============================================================================
//  Module      : tb_byteswap_kernel_ctrl
//  Description : Self-checking bench for byteswap_kernel_ctrl. A second
//                instance with a 4-bit counter shares all inputs so that
//                counter saturation can be observed alongside every run.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_byteswap_kernel_ctrl;

    logic        ap_clk = 1'b0;
    logic        ap_rst_n;
    logic        ap_start;
    logic        ap_idle, ap_done, ap_ready;
    logic [63:0] arg_addr_offset;
    logic [31:0] arg_xfer_size;
    logic [31:0] arg_constant;
    logic [63:0] ctrl_addr_offset;
    logic [31:0] ctrl_xfer_size_in_bytes;
    logic [31:0] ctrl_constant;
    logic        vswap_start;
    logic        vswap_done;
    logic [31:0] busy_cycles;

    logic        s_idle, s_done, s_ready, s_vstart;
    logic [63:0] s_addr;
    logic [31:0] s_size, s_const;
    logic [3:0]  s_busy;

    int n_pass  = 0;
    int n_total = 0;

    always #5 ap_clk = ~ap_clk;

    byteswap_kernel_ctrl dut (
        .ap_clk                  (ap_clk),
        .ap_rst_n                (ap_rst_n),
        .ap_start                (ap_start),
        .ap_idle                 (ap_idle),
        .ap_done                 (ap_done),
        .ap_ready                (ap_ready),
        .arg_addr_offset         (arg_addr_offset),
        .arg_xfer_size           (arg_xfer_size),
        .arg_constant            (arg_constant),
        .ctrl_addr_offset        (ctrl_addr_offset),
        .ctrl_xfer_size_in_bytes (ctrl_xfer_size_in_bytes),
        .ctrl_constant           (ctrl_constant),
        .vswap_start             (vswap_start),
        .vswap_done              (vswap_done),
        .busy_cycles             (busy_cycles)
    );

    byteswap_kernel_ctrl #(.C_CNT_WIDTH(4)) dut_sat (
        .ap_clk                  (ap_clk),
        .ap_rst_n                (ap_rst_n),
        .ap_start                (ap_start),
        .ap_idle                 (s_idle),
        .ap_done                 (s_done),
        .ap_ready                (s_ready),
        .arg_addr_offset         (arg_addr_offset),
        .arg_xfer_size           (arg_xfer_size),
        .arg_constant            (arg_constant),
        .ctrl_addr_offset        (s_addr),
        .ctrl_xfer_size_in_bytes (s_size),
        .ctrl_constant           (s_const),
        .vswap_start             (s_vstart),
        .vswap_done              (vswap_done),
        .busy_cycles             (s_busy)
    );

    // Observations from the most recent run_once call. Cycle k counts from
    // the edge that samples ap_start (k=1 is the first cycle after it).
    int          obs_start_cnt, obs_start_cyc;
    int          obs_done_cnt, obs_done_cyc;
    int          obs_ready_cnt, obs_ready_cyc;
    logic        obs_idle_k1, obs_idle_after, obs_ctrl_bad;
    logic [31:0] obs_busy_k1, obs_busy;
    logic [3:0]  obs_sbusy;

    task automatic tick();
        @(posedge ap_clk);
        #1;
    endtask

    // Reference: a run that is started makes exactly one START cycle plus d
    // RUN cycles (none when size is zero), and completes one cycle after the
    // datapath done is sampled.
    function automatic int exp_done_cyc(input logic [31:0] size, input int d);
        return (size == 0) ? 2 : d + 2;
    endfunction

    function automatic int exp_busy(input logic [31:0] size, input int d, input int maxv);
        int raw;
        raw = (size == 0) ? 1 : d + 1;
        return (raw > maxv) ? maxv : raw;
    endfunction

    // Drives one run from IDLE and records what the DUT does. The datapath
    // done is raised in cycle d+1, i.e. d cycles after the vswap_start cycle.
    task automatic run_once(input logic [63:0] addr, input logic [31:0] size,
                            input logic [31:0] cst, input int d, input bit hold,
                            input bit churn, input bit early, input bit late);
        int bound;
        bound = d + 10;
        obs_start_cnt = 0; obs_start_cyc = -1;
        obs_done_cnt  = 0; obs_done_cyc  = -1;
        obs_ready_cnt = 0; obs_ready_cyc = -1;
        obs_ctrl_bad  = 1'b0; obs_idle_after = 1'bx; obs_idle_k1 = 1'bx;
        obs_busy = 'x; obs_sbusy = 'x; obs_busy_k1 = 'x;
        arg_addr_offset = addr; arg_xfer_size = size; arg_constant = cst;
        ap_start = 1'b1;
        tick();
        for (int k = 1; k <= bound; k++) begin
            if (vswap_start) begin obs_start_cnt++; obs_start_cyc = k; end
            if (ap_done) begin
                obs_done_cnt++; obs_done_cyc = k;
                obs_busy = busy_cycles; obs_sbusy = s_busy;
            end
            if (ap_ready) begin obs_ready_cnt++; obs_ready_cyc = k; end
            if (k == 1) begin obs_idle_k1 = ap_idle; obs_busy_k1 = busy_cycles; end
            if (ctrl_addr_offset !== addr || ctrl_xfer_size_in_bytes !== size ||
                ctrl_constant !== cst)
                obs_ctrl_bad = 1'b1;
            if (obs_done_cnt != 0 && k == obs_done_cyc + 1) begin
                obs_idle_after = ap_idle;
                break;
            end
            if (k == 1) begin
                if (!hold) ap_start = 1'b0;
                if (churn) begin
                    arg_addr_offset = 64'hDEAD;
                    arg_xfer_size   = 32'd8;
                    arg_constant    = 32'd0;
                end
            end
            vswap_done = ((size != 0) && (k == d + 1)) || (early && k == 1) ||
                         (late && ap_done);
            tick();
        end
        vswap_done = 1'b0;
    endtask

    task automatic test_reset();
        ap_rst_n = 1'b0; ap_start = 1'b0; vswap_done = 1'b0;
        arg_addr_offset = '0; arg_xfer_size = '0; arg_constant = '0;
        tick(); tick();
        n_total++; if (ap_idle !== 1'b1) $display("FAIL reset_idle: got %b expected 1", ap_idle); else n_pass++;
        n_total++; if ({ap_done, ap_ready, vswap_start} !== 3'b000)
            $display("FAIL reset_pulses: got %b expected 000", {ap_done, ap_ready, vswap_start}); else n_pass++;
        n_total++; if ({ctrl_addr_offset, ctrl_xfer_size_in_bytes, ctrl_constant, busy_cycles} !== '0)
            $display("FAIL reset_regs: got %h/%h/%h/%h expected all 0", ctrl_addr_offset,
                     ctrl_xfer_size_in_bytes, ctrl_constant, busy_cycles); else n_pass++;
        ap_rst_n = 1'b1;
        tick();
    endtask

    task automatic test_basic();
        run_once(64'h1000, 32'd4096, 32'hA5, 20, 1'b0, 1'b0, 1'b0, 1'b0);
        n_total++; if (obs_start_cnt !== 1 || obs_start_cyc !== 1)
            $display("FAIL basic_vstart: got cnt %0d cyc %0d expected 1/1", obs_start_cnt, obs_start_cyc); else n_pass++;
        n_total++; if (obs_idle_k1 !== 1'b0) $display("FAIL basic_idle_low: got %b expected 0", obs_idle_k1); else n_pass++;
        n_total++; if (obs_ctrl_bad !== 1'b0) $display("FAIL basic_ctrl: got bad=%b expected 0", obs_ctrl_bad); else n_pass++;
        n_total++; if (obs_done_cnt !== 1 || obs_done_cyc !== exp_done_cyc(32'd4096, 20))
            $display("FAIL basic_done: got cnt %0d cyc %0d expected 1/%0d", obs_done_cnt, obs_done_cyc,
                     exp_done_cyc(32'd4096, 20)); else n_pass++;
        n_total++; if (obs_ready_cnt !== 1 || obs_ready_cyc !== obs_done_cyc)
            $display("FAIL basic_ready: got cnt %0d cyc %0d expected 1/%0d", obs_ready_cnt, obs_ready_cyc, obs_done_cyc); else n_pass++;
        n_total++; if (obs_busy !== 32'd21) $display("FAIL basic_busy: got %0d expected 21", obs_busy); else n_pass++;
        n_total++; if (obs_idle_after !== 1'b1) $display("FAIL basic_idle_after: got %b expected 1", obs_idle_after); else n_pass++;
    endtask

    task automatic test_zero_len();
        run_once(64'h2000, 32'd0, 32'h5A, 3, 1'b0, 1'b0, 1'b0, 1'b0);
        n_total++; if (obs_start_cnt !== 0) $display("FAIL zero_vstart: got %0d expected 0", obs_start_cnt); else n_pass++;
        n_total++; if (obs_done_cyc !== 2 || obs_ready_cyc !== 2)
            $display("FAIL zero_done_cyc: got %0d/%0d expected 2/2", obs_done_cyc, obs_ready_cyc); else n_pass++;
        n_total++; if (obs_busy !== 32'd1 || obs_sbusy !== 4'd1)
            $display("FAIL zero_busy: got %0d/%0d expected 1/1", obs_busy, obs_sbusy); else n_pass++;
    endtask

    task automatic test_midrun_churn();
        // Stray datapath done while idle must not start or finish anything.
        vswap_done = 1'b1; tick(); vswap_done = 1'b0;
        n_total++; if (ap_idle !== 1'b1 || ap_done !== 1'b0)
            $display("FAIL idle_done_ignored: got idle %b done %b expected 1/0", ap_idle, ap_done); else n_pass++;
        run_once(64'h3000, 32'd256, 32'h1234, 10, 1'b0, 1'b1, 1'b1, 1'b1);
        n_total++; if (obs_ctrl_bad !== 1'b0) $display("FAIL churn_ctrl: got bad=%b expected 0", obs_ctrl_bad); else n_pass++;
        n_total++; if (obs_done_cnt !== 1 || obs_done_cyc !== exp_done_cyc(32'd256, 10))
            $display("FAIL churn_done: got cnt %0d cyc %0d expected 1/%0d", obs_done_cnt, obs_done_cyc,
                     exp_done_cyc(32'd256, 10)); else n_pass++;
        n_total++; if (obs_busy !== 32'd11) $display("FAIL churn_busy: got %0d expected 11", obs_busy); else n_pass++;
    endtask

    task automatic test_back_to_back();
        run_once(64'h4000, 32'd64, 32'h77, 5, 1'b1, 1'b0, 1'b0, 1'b0);
        n_total++; if (obs_done_cyc !== 7 || obs_idle_after !== 1'b1)
            $display("FAIL b2b_first: got done %0d idle %b expected 7/1", obs_done_cyc, obs_idle_after); else n_pass++;
        tick(); // two cycles after the first ap_done
        n_total++; if (vswap_start !== 1'b1 || ap_idle !== 1'b0)
            $display("FAIL b2b_restart: got vstart %b idle %b expected 1/0", vswap_start, ap_idle); else n_pass++;
        n_total++; if (busy_cycles !== 32'd0) $display("FAIL b2b_busy_clr: got %0d expected 0", busy_cycles); else n_pass++;
        // Done raised already in START is ignored; it is taken one cycle later.
        ap_start = 1'b0; vswap_done = 1'b1;
        tick();
        n_total++; if (ap_done !== 1'b0) $display("FAIL b2b_start_done: got %b expected 0", ap_done); else n_pass++;
        tick(); vswap_done = 1'b0;
        n_total++; if (ap_done !== 1'b1 || busy_cycles !== 32'd2)
            $display("FAIL b2b_second: got done %b busy %0d expected 1/2", ap_done, busy_cycles); else n_pass++;
        tick();
    endtask

    task automatic test_reset_midrun();
        bit bad;
        arg_addr_offset = 64'h5000; arg_xfer_size = 32'd16; arg_constant = 32'h99;
        ap_start = 1'b1; tick(); ap_start = 1'b0;
        tick(); tick(); tick();
        ap_rst_n = 1'b0; tick(); ap_rst_n = 1'b1;
        n_total++; if (ap_idle !== 1'b1 || {ap_done, ap_ready, vswap_start} !== 3'b000)
            $display("FAIL rstrun_state: got idle %b pulses %b expected 1/000", ap_idle,
                     {ap_done, ap_ready, vswap_start}); else n_pass++;
        n_total++; if ({ctrl_addr_offset, ctrl_xfer_size_in_bytes, ctrl_constant} !== '0)
            $display("FAIL rstrun_ctrl: got %h/%h/%h expected 0", ctrl_addr_offset,
                     ctrl_xfer_size_in_bytes, ctrl_constant); else n_pass++;
        bad = 1'b0;
        vswap_done = 1'b1; tick(); vswap_done = 1'b0;
        for (int i = 0; i < 5; i++) begin
            if (ap_done !== 1'b0 || ap_idle !== 1'b1) bad = 1'b1;
            tick();
        end
        n_total++; if (bad !== 1'b0) $display("FAIL rstrun_late_done: got bad=%b expected 0", bad); else n_pass++;
    endtask

    task automatic test_saturation();
        int ds [4] = '{20, 14, 13, 40};
        foreach (ds[i]) begin
            run_once(64'h6000, 32'd32, 32'h1, ds[i], 1'b0, 1'b0, 1'b0, 1'b0);
            n_total++; if (obs_sbusy !== 4'(exp_busy(32'd32, ds[i], 15)))
                $display("FAIL sat_busy_d%0d: got %0d expected %0d", ds[i], obs_sbusy,
                         exp_busy(32'd32, ds[i], 15)); else n_pass++;
            n_total++; if (obs_busy !== 32'(exp_busy(32'd32, ds[i], 1 << 30)))
                $display("FAIL wide_busy_d%0d: got %0d expected %0d", ds[i], obs_busy,
                         exp_busy(32'd32, ds[i], 1 << 30)); else n_pass++;
        end
    endtask

    task automatic test_random_runs();
        for (int it = 0; it < 30; it++) begin
            logic [63:0] a;
            logic [31:0] sz, c;
            int d, gap;
            bit early, late, churn;
            a = {$urandom, $urandom};
            sz = ($urandom_range(0, 3) == 0) ? 32'd0 : $urandom;
            c = $urandom;
            d = $urandom_range(1, 40);
            gap = $urandom_range(0, 3);
            early = $urandom_range(0, 1) == 1;
            late  = $urandom_range(0, 1) == 1;
            churn = $urandom_range(0, 1) == 1;
            for (int g = 0; g < gap; g++) begin
                vswap_done = $urandom_range(0, 1) == 1;
                tick();
                n_total++; if (ap_idle !== 1'b1 || ap_done !== 1'b0)
                    $display("FAIL rnd%0d_gap: got idle %b done %b expected 1/0", it, ap_idle, ap_done); else n_pass++;
            end
            vswap_done = 1'b0;
            run_once(a, sz, c, d, 1'b0, churn, early, late);
            n_total++; if (obs_start_cnt !== ((sz != 0) ? 1 : 0) || (sz != 0 && obs_start_cyc !== 1))
                $display("FAIL rnd%0d_vstart: got cnt %0d cyc %0d size %0d", it, obs_start_cnt, obs_start_cyc, sz); else n_pass++;
            n_total++; if (obs_done_cnt !== 1 || obs_done_cyc !== exp_done_cyc(sz, d) || obs_ready_cyc !== obs_done_cyc)
                $display("FAIL rnd%0d_done: got cnt %0d cyc %0d ready %0d expected 1/%0d", it, obs_done_cnt,
                         obs_done_cyc, obs_ready_cyc, exp_done_cyc(sz, d)); else n_pass++;
            n_total++; if (obs_busy !== 32'(exp_busy(sz, d, 1 << 30)) || obs_sbusy !== 4'(exp_busy(sz, d, 15)))
                $display("FAIL rnd%0d_busy: got %0d/%0d expected %0d/%0d", it, obs_busy, obs_sbusy,
                         exp_busy(sz, d, 1 << 30), exp_busy(sz, d, 15)); else n_pass++;
            n_total++; if (obs_ctrl_bad !== 1'b0 || obs_busy_k1 !== 32'd0 || obs_idle_k1 !== 1'b0 || obs_idle_after !== 1'b1)
                $display("FAIL rnd%0d_misc: got ctrlbad %b busy_k1 %0d idle_k1 %b idle_after %b", it,
                         obs_ctrl_bad, obs_busy_k1, obs_idle_k1, obs_idle_after); else n_pass++;
        end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_zero_len();
        test_midrun_churn();
        test_back_to_back();
        test_reset_midrun();
        test_saturation();
        test_random_runs();
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/byteswap_kernel_ctrl.md
Name: byteswap_kernel_ctrl

Overview:
ap_ctrl_hs sequencer that sits directly upstream of the vswap datapath stage.
- Takes the host-level ap_start and the scalar arguments from the AXI4-Lite control slave.
- Latches the arguments, issues a single-cycle start pulse to the datapath, waits for the datapath done pulse, then returns ap_done/ap_ready/ap_idle to the host.
- Short-circuits zero-length transfers and counts busy cycles for a performance register.

Parameters:
C_M_AXI_ADDR_WIDTH, 64, width of buffer address argument
C_XFER_SIZE_WIDTH, 32, width of transfer-size argument
C_WORD_BIT_WIDTH, 32, width of constant argument
C_CNT_WIDTH, 32, width of busy-cycle counter

Ports:
ap_clk  in  1  kernel clock; single clock domain
ap_rst_n  in  1  reset, synchronous, active-low
ap_start  in  1  level start from control slave; held by host until ap_ready
ap_idle  out  1  high when in IDLE
ap_done  out  1  one-cycle pulse at completion
ap_ready  out  1  one-cycle pulse, coincident with ap_done
arg_addr_offset  in  C_M_AXI_ADDR_WIDTH  host address argument
arg_xfer_size  in  C_XFER_SIZE_WIDTH  host byte-count argument
arg_constant  in  C_WORD_BIT_WIDTH  host constant argument
ctrl_addr_offset  out  C_M_AXI_ADDR_WIDTH  latched address to datapath
ctrl_xfer_size_in_bytes  out  C_XFER_SIZE_WIDTH  latched size to datapath
ctrl_constant  out  C_WORD_BIT_WIDTH  latched constant to datapath
vswap_start  out  1  one-cycle start pulse to datapath
vswap_done  in  1  completion pulse from datapath
busy_cycles  out  C_CNT_WIDTH  cycles spent in START+RUN of last/current run

Behaviour:
- All outputs are registered.
- Reset (ap_rst_n=0 sampled at a rising edge):
  - state=IDLE, ap_idle=1, ap_done=0, ap_ready=0, vswap_start=0.
  - Latched args and busy_cycles are 0.
  - Reset mid-run abandons the run; vswap_done is ignored until a new run enters RUN.
- FSM states: IDLE, START, RUN, DONE.
- IDLE:
  - If ap_start=1: latch all three args, clear busy_cycles, go to START; ap_idle falls the next cycle.
  - Otherwise stay in IDLE.
- START (exactly 1 cycle):
  - If latched size==0: go to DONE with no vswap_start pulse.
  - Else: vswap_start=1 for exactly this cycle, then go to RUN.
- RUN:
  - Wait for vswap_done=1; on that edge go to DONE.
  - A vswap_done already high in the START cycle is ignored; the datapath cannot finish in 0 cycles.
- DONE (exactly 1 cycle): ap_done=1 and ap_ready=1, then go to IDLE with ap_idle=1.
- Latency from the ap_start sample to the vswap_start high cycle is 1 cycle.
- Latency from the vswap_done sample to the ap_done high cycle is 1 cycle.
- busy_cycles:
  - Increments once per cycle in START and in RUN.
  - Saturates at all-ones; no wrap.
  - Holds its value in DONE and IDLE until the next latch.
  - Zero-length run gives busy_cycles=1.
- Latched args are stable from the START cycle until the next IDLE→START transition; host arg changes mid-run have no effect.
- vswap_done pulses in IDLE or DONE are ignored.
- ap_start dropping mid-run is ignored; the run completes.
- Back-to-back: if ap_start is still 1 in the IDLE cycle after DONE, a new run starts. ap_idle is high for that one cycle.

Test Plan:
- Reset, then ap_start=1 with addr=0x1000, size=4096, const=0xA5 → 1 cycle later vswap_start pulses once; ctrl_* = 0x1000/4096/0xA5; ap_idle=0. Drive vswap_done 20 cycles after vswap_start → next cycle ap_done=ap_ready=1 for 1 cycle; busy_cycles=21; ap_idle=1 after.
- size=0 → no vswap_start ever. ap_done/ap_ready high 2 cycles after the ap_start sample; busy_cycles=1.
- Mid-run, change the args to 0xDEAD/8/0 and drop ap_start; pulse vswap_done in IDLE beforehand → ctrl_* unchanged; early done ignored; run completes only on the in-RUN vswap_done.
- Hold ap_start=1 across completion → second vswap_start exactly 2 cycles after the first ap_done. ap_idle is high for that one intervening cycle, and busy_cycles is cleared at the new latch.
- Assert ap_rst_n=0 for 1 cycle while in RUN → next cycle ap_idle=1, all pulses 0, ctrl_*=0. A later vswap_done produces no ap_done.
- Force busy_cycles near max (C_CNT_WIDTH=4, hold RUN 20 cycles) → busy_cycles saturates at 15 with no wrap.
